// File: rtl/fa_bist_checker.sv
// Exhaustive BIST for a 1-bit full adder: walks {A,B,C} through 0..7, holds each HOLD_CYCLES cycles,
// checks {Co,S} on the last hold cycle. Results register one cycle after each sample; no backpressure.
module fa_bist_checker #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  output logic             oA,
  output logic             oB,
  output logic             oC,
  input  logic             iS,
  input  logic             iCo,
  output logic             oBusy,
  output logic             oDone,
  output logic             oPass,
  output logic [ERR_W-1:0] oErrCnt,
  output logic             oFirstErrValid,
  output logic [2:0]       oFirstErrVec
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t           state, state_nxt;
  logic [2:0]       vidx, vidx_nxt;
  logic [2:0]       vec_q, vec_nxt;
  logic [7:0]       hcnt, hcnt_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             fev_nxt;
  logic [2:0]       fevec_nxt;
  logic             pass_nxt;
  logic             done_nxt;
  logic [1:0]       expected;
  logic             mismatch;

  // Reference sum is taken from the registered drive, i.e. what the adder actually sees.
  assign expected = {1'b0, vec_q[2]} + {1'b0, vec_q[1]} + {1'b0, vec_q[0]};
  assign mismatch = ({iCo, iS} != expected);

  assign {oA, oB, oC} = vec_q;
  assign oBusy        = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    vidx_nxt  = vidx;
    hcnt_nxt  = hcnt;
    vec_nxt   = 3'd0;
    err_nxt   = oErrCnt;
    fev_nxt   = oFirstErrValid;
    fevec_nxt = oFirstErrVec;
    pass_nxt  = oPass;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (iStart) begin
          state_nxt = S_APPLY;
          vidx_nxt  = 3'd0;
          hcnt_nxt  = 8'd0;
          err_nxt   = '0;
          fev_nxt   = 1'b0;
          fevec_nxt = 3'd0;
          pass_nxt  = 1'b0;
        end
      end
      S_APPLY: begin
        vec_nxt  = vidx;
        hcnt_nxt = hcnt + 8'd1;
        if (hcnt == HOLD_LAST) begin
          if (mismatch) begin
            if (oErrCnt != '1) err_nxt = oErrCnt + ERR_W'(1);
            if (!oFirstErrValid) begin
              fev_nxt   = 1'b1;
              fevec_nxt = vidx;
            end
          end
          hcnt_nxt = 8'd0;
          // Pass is judged here so it is already valid while DONE/oDone is showing.
          if (vidx == 3'd7) begin
            state_nxt = S_DONE;
            vec_nxt   = 3'd0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_nxt == '0);
          end else begin
            vidx_nxt = vidx + 3'd1;
            vec_nxt  = vidx + 3'd1;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state          <= S_IDLE;
      vidx           <= 3'd0;
      hcnt           <= 8'd0;
      vec_q          <= 3'd0;
      oErrCnt        <= '0;
      oFirstErrValid <= 1'b0;
      oFirstErrVec   <= 3'd0;
      oPass          <= 1'b0;
      oDone          <= 1'b0;
    end else begin
      state          <= state_nxt;
      vidx           <= vidx_nxt;
      hcnt           <= hcnt_nxt;
      vec_q          <= vec_nxt;
      oErrCnt        <= err_nxt;
      oFirstErrValid <= fev_nxt;
      oFirstErrVec   <= fevec_nxt;
      oPass          <= pass_nxt;
      oDone          <= done_nxt;
    end
  end

endmodule

// File: tb/tb_fa_bist_checker.sv
// Bench for fa_bist_checker: cycle-accurate behavioural model on the main instance plus
// directed runs for saturation (ERR_W=2) and back-to-back short holds (HOLD_CYCLES=2).
module tb_fa_bist_checker;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: HOLD_CYCLES=4, ERR_W=4, fault selectable
  logic       start_a, a_a, b_a, c_a, s_a, co_a, busy_a, done_a, pass_a, fev_a;
  logic [3:0] err_a;
  logic [2:0] fvec_a;
  int         fault_a;

  // Saturation instance: carry inverted, ERR_W=2
  logic       start_b, a_b, b_b, c_b, s_b, co_b, busy_b, done_b, pass_b, fev_b;
  logic [1:0] err_b;
  logic [2:0] fvec_b;

  // Short-hold instance: HOLD_CYCLES=2, correct adder
  logic       start_c, a_c, b_c, c_c, s_c, co_c, busy_c, done_c, pass_c, fev_c;
  logic [3:0] err_c;
  logic [2:0] fvec_c;

  function automatic bit fa_resp_bit(int f, int sum, bit carry);
    if (carry) return (f == 2) ? !(sum / 2) : bit'(sum / 2);
    return (f == 1) ? 1'b0 : bit'(sum % 2);
  endfunction

  always_comb begin
    s_a  = fa_resp_bit(fault_a, int'(a_a) + int'(b_a) + int'(c_a), 1'b0);
    co_a = fa_resp_bit(fault_a, int'(a_a) + int'(b_a) + int'(c_a), 1'b1);
    s_b  = fa_resp_bit(2, int'(a_b) + int'(b_b) + int'(c_b), 1'b0);
    co_b = fa_resp_bit(2, int'(a_b) + int'(b_b) + int'(c_b), 1'b1);
    s_c  = fa_resp_bit(0, int'(a_c) + int'(b_c) + int'(c_c), 1'b0);
    co_c = fa_resp_bit(0, int'(a_c) + int'(b_c) + int'(c_c), 1'b1);
  end

  fa_bist_checker #(.HOLD_CYCLES(4), .ERR_W(4)) dut_a (
    .iClk(clk), .iRst(rst), .iStart(start_a), .oA(a_a), .oB(b_a), .oC(c_a),
    .iS(s_a), .iCo(co_a), .oBusy(busy_a), .oDone(done_a), .oPass(pass_a),
    .oErrCnt(err_a), .oFirstErrValid(fev_a), .oFirstErrVec(fvec_a));

  fa_bist_checker #(.HOLD_CYCLES(4), .ERR_W(2)) dut_b (
    .iClk(clk), .iRst(rst), .iStart(start_b), .oA(a_b), .oB(b_b), .oC(c_b),
    .iS(s_b), .iCo(co_b), .oBusy(busy_b), .oDone(done_b), .oPass(pass_b),
    .oErrCnt(err_b), .oFirstErrValid(fev_b), .oFirstErrVec(fvec_b));

  fa_bist_checker #(.HOLD_CYCLES(2), .ERR_W(4)) dut_c (
    .iClk(clk), .iRst(rst), .iStart(start_c), .oA(a_c), .oB(b_c), .oC(c_c),
    .iS(s_c), .iCo(co_c), .oBusy(busy_c), .oDone(done_c), .oPass(pass_c),
    .oErrCnt(err_c), .oFirstErrValid(fev_c), .oFirstErrVec(fvec_c));

  // Model of dut_a in run-relative time: vector k sampled at run cycle 4(k+1), done at 33.
  function automatic bit vec_fails(int f, int k);
    int sum;
    sum = ((k >> 2) & 1) + ((k >> 1) & 1) + (k & 1);
    return (fa_resp_bit(f, sum, 1'b0) != bit'(sum % 2)) || (fa_resp_bit(f, sum, 1'b1) != bit'(sum / 2));
  endfunction

  bit       m_run;
  int       m_t0, m_cnt;
  bit       m_fev, m_pass;
  bit [2:0] m_fvec;
  int       mc, mk;
  bit       mfail;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 0; m_t0 <= 0; m_cnt <= 0; m_fev <= 0; m_fvec <= 0; m_pass <= 0;
    end else begin
      mc = cyc - m_t0;
      if ((!m_run || mc >= 34) && start_a) begin
        m_run <= 1; m_t0 <= cyc; m_cnt <= 0; m_fev <= 0; m_fvec <= 0; m_pass <= 0;
      end else if (m_run && mc >= 4 && mc <= 32 && mc % 4 == 0) begin
        mk    = mc / 4 - 1;
        mfail = vec_fails(fault_a, mk);
        if (mfail && m_cnt < 15) m_cnt <= m_cnt + 1;
        if (mfail && !m_fev) begin m_fev <= 1; m_fvec <= 3'(mk); end
        if (mk == 7) m_pass <= (m_cnt == 0) && !mfail;
      end
    end
  end

  int        ec;
  bit [14:0] exp_v, act_v;
  always @(negedge clk) begin
    if (chk_on) begin
      ec = cyc - m_t0;
      exp_v = {(m_run && ec >= 1 && ec <= 32) ? 3'((ec - 1) / 4) : 3'd0,
               m_run && ec >= 1 && ec <= 33, m_run && ec == 33, m_pass,
               4'(m_cnt), m_fev, m_fvec};
      act_v = {a_a, b_a, c_a, busy_a, done_a, pass_a, err_a, fev_a, fvec_a};
      n_chk++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL model_cycle cyc=%0d got=%h expected=%h", cyc, act_v, exp_v);
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int rel, da_n, da_at, dc_n, dc1, dc2;

  task automatic step();
    @(negedge clk);
    rel++;
    if (done_a === 1'b1) begin da_n++; da_at = rel; end
    if (done_c === 1'b1) begin dc_n++; if (dc_n == 1) dc1 = rel; else dc2 = rel; end
  endtask

  task automatic begin_run();
    rel = 0; da_n = 0; da_at = -1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  initial begin
    start_a = 0; start_b = 0; start_c = 0; fault_a = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_err", int'(err_a), 0);
    chk("reset_vec", int'({a_a, b_a, c_a}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean run on all three instances; dut_c keeps start high for back-to-back runs
    dc_n = 0; dc1 = -1; dc2 = -1;
    start_b = 1'b1; start_c = 1'b1;
    begin_run();
    start_b = 1'b0;
    while (rel < 40) begin
      step();
      if (rel == 13) chk("vec_at_13", int'({a_a, b_a, c_a}), 3);
      if (rel == 32) chk("vec_at_32", int'({a_a, b_a, c_a}), 7);
      if (rel == 35) start_c = 1'b0;
    end
    chk("clean_done_count", da_n, 1);
    chk("clean_done_cycle", da_at, 33);
    chk("clean_pass", int'(pass_a), 1);
    chk("clean_fev", int'(fev_a), 0);
    chk("h2_done_count", dc_n, 2);
    chk("h2_done_first", dc1, 17);
    chk("h2_done_second", dc2, 35);
    chk("h2_pass", int'(pass_c), 1);
    chk("sat_err", int'(err_b), 3);
    chk("sat_fvec", int'(fvec_b), 0);
    chk("sat_fev", int'(fev_b), 1);
    chk("sat_pass", int'(pass_b), 0);

    // Start re-pulsed during APPLY (vector 3) and during DONE
    begin_run();
    while (rel < 40) begin
      step();
      if (rel == 13 || rel == 33) start_a = 1'b1;
      if (rel == 14 || rel == 34) start_a = 1'b0;
    end
    chk("repulse_done_count", da_n, 1);
    chk("repulse_done_cycle", da_at, 33);
    chk("repulse_pass", int'(pass_a), 1);

    // Sum output stuck at 0
    fault_a = 1;
    begin_run();
    while (rel < 40) begin
      step();
      if (rel == 8) chk("stuck_err_before_update", int'(err_a), 0);
      if (rel == 9) chk("stuck_err_after_update", int'(err_a), 1);
    end
    chk("stuck_err", int'(err_a), 4);
    chk("stuck_fvec", int'(fvec_a), 1);
    chk("stuck_fev", int'(fev_a), 1);
    chk("stuck_pass", int'(pass_a), 0);

    // Asynchronous reset in the middle of vector 5, then a fresh clean run
    begin_run();
    while (rel < 22) step();
    chk("pre_reset_err", int'(err_a), 3);
    chk("pre_reset_vec", int'({a_a, b_a, c_a}), 5);
    #2 rst = 1'b1;
    #1;
    chk("async_vec", int'({a_a, b_a, c_a}), 0);
    chk("async_busy", int'(busy_a), 0);
    chk("async_err", int'(err_a), 0);
    chk("async_fev", int'({fev_a, fvec_a}), 0);
    @(negedge clk);
    rst = 1'b0;
    fault_a = 0;
    @(negedge clk);
    begin_run();
    chk("restart_vec0_busy", int'({busy_a, a_a, b_a, c_a}), 8);
    while (rel < 40) step();
    chk("restart_done_cycle", da_at, 33);
    chk("restart_pass", int'(pass_a), 1);
    chk("restart_err", int'(err_a), 0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fa_bist_checker.md
# fa_bist_checker

Built-in self-test sequencer and response checker for the 1-bit full adder `FA`. On request it drives all eight `{iA,iB,iC}` input combinations into an `FA` instance and samples the `oS`/`oC` response of each one. It compares every response against the arithmetic sum and reports the pass/fail status, a saturating error count and the first failing vector. It sits beside the `FA` instance in hardware and gives the same coverage as the exhaustive stimulus bench, with no simulator needed.

## Interface
- `HOLD_CYCLES`, default 4: cycles each vector is held on the DUT inputs. Legal values are 2 to 255.
- `ERR_W`, default 4: width of the error counter.

- `iClk`, input, 1: clock. All state changes on the rising edge.
- `iRst`, input, 1: reset. Asynchronous and active-high. Clears all state immediately.
- `iStart`, input, 1: run request. Sampled only in IDLE.
- `oA`, output, 1: drives `FA.iA`.
- `oB`, output, 1: drives `FA.iB`.
- `oC`, output, 1: drives `FA.iC`.
- `iS`, input, 1: from `FA.oS`.
- `iCo`, input, 1: from `FA.oC`.
- `oBusy`, output, 1: high in APPLY and DONE.
- `oDone`, output, 1: one-cycle pulse at the end of a run.
- `oPass`, output, 1: result of the last completed run. High only if the error count is 0.
- `oErrCnt`, output, ERR_W: mismatch count. Saturates at 2^ERR_W−1.
- `oFirstErrValid`, output, 1: high once a mismatch has been captured in the current or last run.
- `oFirstErrVec`, output, 3: `{A,B,C}` of the first mismatching vector.

## Operation
- The FSM has three states: IDLE, APPLY and DONE.
- **Reset values**: state is IDLE. `oA`, `oB`, `oC`, `oBusy`, `oDone`, `oPass` and `oFirstErrValid` are 0. `oErrCnt` and `oFirstErrVec` are 0. The internal vector index `vidx` (3 bits) and hold counter `hcnt` (8 bits) are 0.
- **IDLE**:
  - `oA`, `oB` and `oC` are 0.
  - When `iStart` is 1, go to APPLY. At the same time clear `vidx`, `hcnt`, `oErrCnt`, `oFirstErrValid` and `oFirstErrVec`, and clear `oPass`.
  - Result outputs otherwise hold their values from the last run.
- **APPLY**:
  - `{oA,oB,oC}` equals `vidx`, with `oA` as the MSB. These outputs are registered.
  - `hcnt` increments every cycle.
  - On the cycle where `hcnt` equals `HOLD_CYCLES`−1 (the sample cycle):
    - Compute the expected value as `{Co,S}` = `oA` + `oB` + `oC` (2-bit sum).
    - A mismatch is `{iCo,iS}` not equal to the expected value.
    - On a mismatch, increment `oErrCnt` unless it is already all ones.
    - If `oFirstErrValid` is 0, latch `oFirstErrVec` = `vidx` and set `oFirstErrValid`.
    - Then clear `hcnt`. If `vidx` is 7, go to DONE. Otherwise increment `vidx`.
  - `iStart` is ignored.
- **DONE**:
  - Lasts exactly one cycle. `oDone` is 1.
  - `oPass` is loaded with (`oErrCnt` == 0), including any error counted on the final sample.
  - `{oA,oB,oC}` returns to 0. Next state is IDLE.
  - `iStart` is ignored in this cycle.
- **Responses between sample cycles** are not inspected. The settle time given to the DUT is `HOLD_CYCLES`−1 cycles.
- **Saturation**: once `oErrCnt` is all ones, further mismatches leave it unchanged. `oPass` still evaluates to 0.

## Timing
- **Start**: if the start edge is cycle 0, the first APPLY cycle is cycle 1 and vector 0 is on `oA`/`oB`/`oC` during cycle 1.
- **Vector k** is driven during cycles 1+k·`HOLD_CYCLES` through (k+1)·`HOLD_CYCLES`. It is sampled on the last of those cycles.
- **Done**: `oDone` is high in cycle 8·`HOLD_CYCLES`+1. IDLE resumes at cycle 8·`HOLD_CYCLES`+2.
- **Result updates**: `oPass` becomes valid in the same cycle as `oDone`. `oErrCnt` and `oFirstErr*` update the cycle after their sample cycle.
- **Back-to-back runs**: `iStart` held high continuously restarts a run on the first IDLE cycle after DONE.
- **Reset mid-run**: all outputs return to their reset values asynchronously. No partial result survives. The next `iStart` in IDLE starts a fresh run from vector 0.

## Test plan
- **Correct FA, `HOLD_CYCLES`=4, `iStart` pulsed at cycle 0**: `oDone` is high at cycle 33 only, `oBusy` is high for cycles 1–33, `oPass`=1, `oErrCnt`=0 and `oFirstErrValid`=0. The driven vectors are 000 through 111 in order, with each held for 4 cycles.
- **`iS` stuck at 0**: the vectors with odd parity (1, 2, 4, 7) fail. Expect `oErrCnt`=4, `oFirstErrVec`=3'b001, `oFirstErrValid`=1 and `oPass`=0.
- **`iCo` inverted, `ERR_W`=2**: all 8 vectors mismatch. `oErrCnt` saturates at 3, `oFirstErrVec`=000 and `oPass`=0.
- **`iStart` re-pulsed during APPLY (vector 3) and during DONE**: both pulses are ignored, so `oDone` fires once at cycle 33 and the vector sequence is unchanged.
- **`iRst` asserted at vector 5 mid-cycle, then `iStart`**: all outputs go to 0 immediately, without waiting for a clock edge. The new run starts at vector 0 and completes with `oPass`=1 after 8·`HOLD_CYCLES`+1 cycles.
- **`HOLD_CYCLES`=2, correct FA, `iStart` held high**: runs repeat back to back, with `oDone` at cycles 17 and 35 and `oPass` staying 1.
